// File: rtl/ysyx_23060203_axi_if.sv
// AXI4 read-side bundle (AR + R channels) shared by masters, arbiter and crossbar.
// Ports: none; master drives AR payload/arvalid and rready, slave drives arready and R payload.
// Widths fixed: araddr 32, arid 4, arlen 8, arsize 3, arburst 2, rdata 32, rresp 2, rid 4.
interface ysyx_23060203_axi_if;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast, rid
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast, rid
   );
endinterface

// File: rtl/ysyx_23060203_rd_arbiter.sv
// Two-master (IFU/LSU) AXI4 read arbiter, one burst outstanding, round-robin grant held until rlast.
// Latency: AR registered (master handshake T -> out_r.arvalid T+1); R routed combinationally (0 cycles).
// Ports: clock, reset (sync, active-high), ifu_r/lsu_r (slave side), out_r (to crossbar), err (sticky).
module ysyx_23060203_rd_arbiter (
   input  logic                     clock,
   input  logic                     reset,
   ysyx_23060203_axi_if.slave       ifu_r,
   ysyx_23060203_axi_if.slave       lsu_r,
   ysyx_23060203_axi_if.master      out_r,
   output logic                     err
);

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      ADDR = 3'b010,
      DATA = 3'b100
   } state_t;

   state_t      state, state_nxt;
   logic        owner;   // 0 = IFU, 1 = LSU
   logic        prio;    // master that wins a simultaneous request
   logic [31:0] ar_addr;
   logic [3:0]  ar_id;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic [7:0]  beats;   // beats remaining after the current one

   logic        any_req;
   logic        win;
   logic        r_hs;

   // The buffered AR means grant never waits on the crossbar's arready.
   assign any_req = ifu_r.arvalid | lsu_r.arvalid;
   assign win     = (ifu_r.arvalid & lsu_r.arvalid) ? prio : lsu_r.arvalid;
   assign r_hs    = (state == DATA) & out_r.rvalid & out_r.rready;

   assign out_r.araddr  = ar_addr;
   assign out_r.arid    = ar_id;
   assign out_r.arlen   = ar_len;
   assign out_r.arsize  = ar_size;
   assign out_r.arburst = ar_burst;

   always_comb begin
      state_nxt     = state;
      ifu_r.arready = 1'b0;
      lsu_r.arready = 1'b0;
      out_r.arvalid = 1'b0;
      out_r.rready  = 1'b0;
      ifu_r.rvalid  = 1'b0;
      ifu_r.rdata   = 32'd0;
      ifu_r.rresp   = 2'd0;
      ifu_r.rlast   = 1'b0;
      ifu_r.rid     = 4'd0;
      lsu_r.rvalid  = 1'b0;
      lsu_r.rdata   = 32'd0;
      lsu_r.rresp   = 2'd0;
      lsu_r.rlast   = 1'b0;
      lsu_r.rid     = 4'd0;
      case (state)
         IDLE: begin
            ifu_r.arready = any_req & ~win;
            lsu_r.arready = any_req & win;
            if (any_req) state_nxt = ADDR;
         end
         ADDR: begin
            out_r.arvalid = 1'b1;
            if (out_r.arready) state_nxt = DATA;
         end
         DATA: begin
            if (owner) begin
               lsu_r.rvalid = out_r.rvalid;
               lsu_r.rdata  = out_r.rdata;
               lsu_r.rresp  = out_r.rresp;
               lsu_r.rlast  = out_r.rlast;
               lsu_r.rid    = out_r.rid;
               out_r.rready = lsu_r.rready;
            end else begin
               ifu_r.rvalid = out_r.rvalid;
               ifu_r.rdata  = out_r.rdata;
               ifu_r.rresp  = out_r.rresp;
               ifu_r.rlast  = out_r.rlast;
               ifu_r.rid    = out_r.rid;
               out_r.rready = ifu_r.rready;
            end
            if (r_hs && out_r.rlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= 1'b0;
         prio     <= 1'b1;
         ar_addr  <= 32'd0;
         ar_id    <= 4'd0;
         ar_len   <= 8'd0;
         ar_size  <= 3'd0;
         ar_burst <= 2'd0;
         beats    <= 8'd0;
         err      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_req) begin
            owner    <= win;
            ar_addr  <= win ? lsu_r.araddr  : ifu_r.araddr;
            ar_id    <= win ? lsu_r.arid    : ifu_r.arid;
            ar_len   <= win ? lsu_r.arlen   : ifu_r.arlen;
            ar_size  <= win ? lsu_r.arsize  : ifu_r.arsize;
            ar_burst <= win ? lsu_r.arburst : ifu_r.arburst;
            beats    <= win ? lsu_r.arlen   : ifu_r.arlen;
         end
         if (r_hs) begin
            // rlast disagreeing with the beat count is flagged, but rlast still ends the burst.
            if (out_r.rlast != (beats == 8'd0)) err <= 1'b1;
            if (out_r.rlast) prio <= ~owner;
            else             beats <= beats - 8'd1;
         end
      end
   end

endmodule

// File: doc/ysyx_23060203_rd_arbiter.md
# ysyx_23060203_rd_arbiter

Two-master AXI4 read arbiter sitting directly upstream of the read crossbar. It merges the instruction-fetch (IFU) and load/store (LSU) read ports into the single read port that feeds the crossbar. One burst is outstanding at a time, and the AR request is registered towards the crossbar. Grant is round-robin, and it is held from AR acceptance until the last R beat.

## Interface
- No parameters. All channel widths are fixed by `ysyx_23060203_axi_if`:
  - araddr 32, arid 4, arlen 8, arsize 3, arburst 2
  - rdata 32, rresp 2, rlast 1, rid 4
- `clock` — in — 1 — clock.
- `reset` — in — 1 — reset, synchronous, active-high.
- `ifu_r` — axi_if.in — AR+R — IFU read master. Uses AR and R signals only.
- `lsu_r` — axi_if.in — AR+R — LSU read master. Uses AR and R signals only.
- `out_r` — axi_if.out — AR+R — merged read port to the crossbar.
- `err` — out — 1 — sticky protocol-error flag. Cleared only by reset.

## Operation
- State machine with one-hot states IDLE, ADDR, DATA. Registers:
  - `owner`: 0 = IFU, 1 = LSU.
  - `prio`: the master that wins a tie.
  - AR register: addr, id, len, size, burst.
  - `beats`: 8-bit beat counter.
- IDLE:
  - `win` is computed combinationally:
    - only one master asserts arvalid → that master wins;
    - both assert arvalid → `prio` wins.
  - `win.arready = 1`; the other master sees `arready = 0`.
  - `win.arready` does not depend on `out_r.arready`, because the request is buffered.
  - On handshake: capture the AR fields, set `owner = win`, load `beats = arlen`, go to ADDR.
- ADDR:
  - `out_r.arvalid = 1`, driven from the AR register. Fields stay stable until handshake.
  - On `out_r.arready` → DATA.
- DATA: routing
  - R channel is passed through combinationally:
    - `owner.rvalid = out_r.rvalid`, and `owner.{rdata,rresp,rid,rlast}` mirror `out_r`;
    - `out_r.rready = owner.rready`.
  - Non-owner: `rvalid = 0`, `rdata`/`rresp`/`rid`/`rlast = 0`.
- DATA: on each R handshake
  - if `rlast = 1`: go to IDLE and set `prio = ~owner` (loser of this burst wins the next tie).
  - else: `beats <= beats − 1` (8-bit; wrap is impossible in legal traffic).
- Error checks. Each sets `err` sticky; the FSM still follows `rlast`:
  - `rlast = 1` while `beats != 0`;
  - `rlast = 0` while `beats == 0`.
- Outside DATA:
  - `out_r.rready = 0`;
  - both masters see `rvalid = 0`.
- `out_r.arvalid` is 0 outside ADDR.
- rresp is forwarded unmodified. SLVERR/DECERR do not set `err`.

## Timing
- Reset values:
  - state IDLE, `owner = 0`, `prio = 1` (LSU wins the first tie);
  - `beats = 0`, `err = 0`, AR register 0;
  - `out_r.arvalid = 0`, `out_r.rready = 0`;
  - both masters: `arready = 0` until the first IDLE evaluation with arvalid, `rvalid = 0`.
- AR latency:
  - master handshake in cycle T → `out_r.arvalid = 1` from cycle T+1;
  - `out_r.arvalid` holds until `out_r.arready` is sampled high.
- R latency: zero cycles. `out_r.rvalid` in cycle N → `owner.rvalid` in cycle N.
- Turnaround:
  - last beat in cycle L → IDLE in L+1;
  - a new master AR handshake is possible in L+1.
  - Minimum spacing between AR acceptances = 3 cycles for single-beat bursts with zero-wait downstream.
- arvalid arriving while busy: the master waits with `arready = 0` and no starvation.
- Round-robin bounds a waiting master to one burst of the other master.
- Simultaneous arvalid on both masters in IDLE: exactly one arready is high, chosen by `prio`.
- Reset mid-burst:
  - abandons the burst; next cycle the block is in IDLE with reset values;
  - the downstream crossbar shares `reset` and is cleared in the same cycle.
- A master deasserting arvalid before handshake is illegal AXI and is not handled.

## Test plan
- Single IFU read:
  - stimulus: araddr 0x3000_0000, arlen 0, with `out_r.arready` stuck high;
  - `out_r.arvalid` 1 cycle after handshake with identical fields;
  - rdata 0xDEADBEEF / rlast returned to IFU only, LSU rvalid stays 0, block back in IDLE one cycle after the beat.
- Tie after reset:
  - stimulus: IFU (0x3000_0000) and LSU (0x8000_0010) arvalid together;
  - LSU is granted first, then IFU;
  - repeat the tie: LSU is granted first again (priority alternates per burst).
- LSU burst:
  - stimulus: arlen 3, 4 beats 0x11,0x22,0x33,0x44 with rlast on beat 4, IFU rready toggling;
  - all four beats reach LSU in order, `err = 0`;
  - arready is 0 to IFU throughout, even with IFU arvalid held high.
- Downstream stall:
  - stimulus: `out_r.arready = 0` for 5 cycles;
  - `out_r.arvalid` stays 1 with stable fields;
  - no second master accepted in that time.
- Protocol errors:
  - arlen 1 with rlast on beat 1 → `err = 1` and state returns to IDLE; `err` stays 1 through later legal bursts until reset.
  - arlen 0 with rlast = 0 on beat 1 → `err = 1`.
- Mid-burst reset:
  - stimulus: assert reset during beat 2 of 4;
  - next cycle all outputs are at their reset values and state is IDLE;
  - a new IFU read then completes normally.
